keypad_entry_scanner: RTL and testbench
=======================================

KEYPAD_ENTRY_SCANNER -- requirements
Module: keypad_entry_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, meaning clk cycles each column is driven (dwell), minimum 4.
REQ-002 The block SHALL have parameter DEBOUNCE_SCANS, default 4, meaning consecutive matching dwell samples required to accept a press or release, minimum 1.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have ports KR_0..KR_3  input  1 each  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 The block SHALL have ports KC_0..KC_3  output  1 each  keypad column drive, active-low, one-hot-low.
REQ-007 The block SHALL have port entry  output  16  current decimal-entry accumulator, binary, 0..9999.
REQ-008 The block SHALL have port value  output  16  last committed entry, binary.
REQ-009 The block SHALL have port value_valid  output  1  one-cycle pulse when value is updated.
REQ-010 The block SHALL have port key_code  output  4  last accepted key: 0-9 digits, A-D = 0xA-0xD, '*' = 0xE, '#' = 0xF.
REQ-011 The block SHALL have port key_strobe  output  1  one-cycle pulse per accepted key press.
REQ-012 The block SHALL have port digit_count  output  3  digits held in entry, 0..4.

Function
REQ-013 Rows SHALL pass through a 2-flop synchronizer before use; rows are sampled in the last cycle of each dwell.
REQ-014 Keymap (row r, column c) SHALL be: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
REQ-015 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-016 SCAN: the active column SHALL advance 0->1->2->3->0 after each dwell; a sample with any row low SHALL latch column and row pattern and go to DEBOUNCE with the column held.
REQ-017 DEBOUNCE: each dwell sample equal to the latched pattern SHALL increment a count; reaching DEBOUNCE_SCANS (first sample included) SHALL accept the key and go to PRESSED; any differing sample SHALL return to SCAN, advancing the column.
REQ-018 Acceptance SHALL, on one edge, load key_code, pulse key_strobe, and update entry, digit_count, value, value_valid as in REQ-020..023.
REQ-019 If several rows are low in the latched pattern, the lowest-index row SHALL be decoded.
REQ-020 Digit d with digit_count < 4: entry SHALL become entry*10 + d, and digit_count SHALL increment; with digit_count = 4 the digit SHALL be ignored (key_strobe still pulses).
REQ-021 '*' SHALL clear entry and digit_count to 0.
REQ-022 '#' SHALL copy entry to value, pulse value_valid, and clear entry and digit_count; '#' with digit_count = 0 SHALL commit value = 0.
REQ-023 Keys A-D SHALL change only key_code and key_strobe.
REQ-024 PRESSED: the column SHALL stay held; a dwell sample with all rows high SHALL go to RELEASE; no further strobes SHALL occur while held.
REQ-025 RELEASE: DEBOUNCE_SCANS consecutive all-high samples SHALL return to SCAN with the column advanced; any low sample SHALL return to PRESSED with no strobe.
REQ-026 Exactly one KC output SHALL be low at all times after reset.

Reset
REQ-027 rst SHALL asynchronously force: state SCAN, column 0 (KC_0 = 0, KC_1..KC_3 = 1), entry = 0, value = 0, digit_count = 0, key_code = 0, key_strobe = 0, value_valid = 0, dwell and debounce counters = 0, synchronizers = all 1.
REQ-028 Reset asserted mid-press SHALL discard the press; after release of rst a still-held key SHALL be re-detected from SCAN and accepted once.

Configuration
REQ-029 Macro KEYPAD_DEBOUNCE_EN defined: REQ-017 and REQ-025 SHALL apply with DEBOUNCE_SCANS.
REQ-030 Macro KEYPAD_DEBOUNCE_EN undefined: DEBOUNCE_SCANS SHALL be treated as 1 and the debounce counter SHALL not be built; accept on first low sample, release on first all-high sample.

Verification
REQ-031 With SCAN_DIV = 4, DEBOUNCE_SCANS = 3 and the macro defined, press '5' (r1, c1) -> one key_strobe, key_code = 5, entry = 5, digit_count = 1.
REQ-032 Keys 1,2,3,4,5,'#' -> entry = 1234 before '#', fifth digit ignored; on '#' value = 1234, single value_valid pulse, entry = 0.
REQ-033 Key 7 bounced low-high-low across dwells, each bounce shorter than 3 dwells -> no key_strobe until 3 consecutive low samples, then exactly one strobe.
REQ-034 Keys 9, '*', '#' -> entry = 0 after '*', value = 0 with value_valid on '#'.
REQ-035 Hold '1' and assert rst mid-PRESSED -> all outputs at reset values; after rst deasserts, exactly one strobe with key_code = 1.
REQ-036 With the macro undefined, press 'A' for one dwell -> key_strobe, key_code = 0xA, entry unchanged.

Source files
------------

// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad column scanner with row debounce and a four-digit decimal entry accumulator.
// Define KEYPAD_DEBOUNCE_EN to build the press/release debounce counter (otherwise one sample decides).
module keypad_entry_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        KR_0,
    input  logic        KR_1,
    input  logic        KR_2,
    input  logic        KR_3,
    output logic        KC_0,
    output logic        KC_1,
    output logic        KC_2,
    output logic        KC_3,
    output logic [15:0] entry,
    output logic [15:0] value,
    output logic        value_valid,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic [2:0]  digit_count
);
    // state    | meaning
    // SCAN     | rotating columns, waiting for any row low
    // DEBOUNCE | column held, counting samples equal to the latched rows
    // PRESSED  | key accepted, column held until rows all high
    // RELEASE  | counting all-high samples before scanning again

    localparam int DWW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DEB_N = DEBOUNCE_SCANS;
`else
    localparam int DEB_N = 1;
`endif

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1) begin : g_param_check
        $error("keypad_entry_scanner: SCAN_DIV must be >= 4 and DEBOUNCE_SCANS >= 1");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t         state, state_nxt;
    logic [3:0]     row_meta, row_sync, lat_row, acc_row, acc_code;
    logic [DWW-1:0] dwell_cnt;
    logic [1:0]     col, acc_r;
    logic [3:0]     kc;
    logic           dwell_end, any_low, same, deb_last;
    logic           col_adv, latch, accept;

    assign dwell_end = (dwell_cnt == DWW'(SCAN_DIV - 1));
    assign any_low   = ~&row_sync;
    assign same      = (row_sync == lat_row);
    assign {KC_3, KC_2, KC_1, KC_0} = kc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            dwell_cnt <= '0;
            state     <= SCAN;
            col       <= 2'd0;
            kc        <= 4'b1110;
            lat_row   <= 4'hF;
        end else begin
            row_meta  <= {KR_3, KR_2, KR_1, KR_0};
            row_sync  <= row_meta;
            dwell_cnt <= dwell_end ? '0 : dwell_cnt + DWW'(1);
            state     <= state_nxt;
            if (col_adv) begin
                col <= col + 2'd1;
                kc  <= {kc[2:0], kc[3]};
            end
            if (latch) lat_row <= row_sync;
        end
    end

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int DBW = $clog2(DEB_N + 1);
    logic [DBW-1:0] deb_cnt;

    // Counts matching samples in DEBOUNCE and all-high samples in RELEASE; the entering sample counts as one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt <= '0;
        end else if (dwell_end) begin
            if ((state == SCAN && any_low) || (state == PRESSED && !any_low))
                deb_cnt <= DBW'(1);
            else if ((state == DEBOUNCE && same) || (state == RELEASE && !any_low))
                deb_cnt <= deb_cnt + DBW'(1);
        end
    end
    assign deb_last = (deb_cnt == DBW'(DEB_N - 1));
`else
    assign deb_last = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        col_adv   = 1'b0;
        latch     = 1'b0;
        accept    = 1'b0;
        acc_row   = lat_row;
        if (dwell_end) begin
            case (state)
                SCAN: begin
                    if (any_low) begin
                        latch   = 1'b1;
                        acc_row = row_sync;
                        if (DEB_N == 1) begin
                            accept    = 1'b1;
                            state_nxt = PRESSED;
                        end else begin
                            state_nxt = DEBOUNCE;
                        end
                    end else begin
                        col_adv = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!same) begin
                        state_nxt = SCAN;
                        col_adv   = 1'b1;
                    end else if (deb_last) begin
                        accept    = 1'b1;
                        state_nxt = PRESSED;
                    end
                end
                PRESSED: begin
                    if (!any_low) begin
                        if (DEB_N == 1) begin
                            state_nxt = SCAN;
                            col_adv   = 1'b1;
                        end else begin
                            state_nxt = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (any_low) begin
                        state_nxt = PRESSED;
                    end else if (deb_last) begin
                        state_nxt = SCAN;
                        col_adv   = 1'b1;
                    end
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    // Lowest-index low row wins when several rows are pulled down together.
    always_comb begin
        if (!acc_row[0])      acc_r = 2'd0;
        else if (!acc_row[1]) acc_r = 2'd1;
        else if (!acc_row[2]) acc_r = 2'd2;
        else                  acc_r = 2'd3;
        case ({acc_r, col})
            4'b0000: acc_code = 4'h1;
            4'b0001: acc_code = 4'h2;
            4'b0010: acc_code = 4'h3;
            4'b0011: acc_code = 4'hA;
            4'b0100: acc_code = 4'h4;
            4'b0101: acc_code = 4'h5;
            4'b0110: acc_code = 4'h6;
            4'b0111: acc_code = 4'hB;
            4'b1000: acc_code = 4'h7;
            4'b1001: acc_code = 4'h8;
            4'b1010: acc_code = 4'h9;
            4'b1011: acc_code = 4'hC;
            4'b1100: acc_code = 4'hE;
            4'b1101: acc_code = 4'h0;
            4'b1110: acc_code = 4'hF;
            default: acc_code = 4'hD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry       <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            key_code    <= '0;
            key_strobe  <= 1'b0;
            digit_count <= '0;
        end else begin
            key_strobe  <= 1'b0;
            value_valid <= 1'b0;
            if (accept) begin
                key_code   <= acc_code;
                key_strobe <= 1'b1;
                if (acc_code <= 4'd9) begin
                    if (digit_count < 3'd4) begin
                        entry       <= entry * 16'd10 + {12'd0, acc_code};
                        digit_count <= digit_count + 3'd1;
                    end
                end else if (acc_code == 4'hE) begin
                    entry       <= '0;
                    digit_count <= '0;
                end else if (acc_code == 4'hF) begin
                    value       <= entry;
                    value_valid <= 1'b1;
                    entry       <= '0;
                    digit_count <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Directed bench for keypad_entry_scanner: a keypad matrix model, a key-sequence table and
// hand-timed sequences for bounce, multi-row, single-dwell and reset-mid-press cases.
module tb_keypad_entry_scanner;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        KR_0, KR_1, KR_2, KR_3;
    logic        KC_0, KC_1, KC_2, KC_3;
    logic [15:0] entry, value;
    logic        value_valid, key_strobe;
    logic [3:0]  key_code;
    logic [2:0]  digit_count;

    logic [3:0]  key_rows = 4'h0;
    logic [1:0]  key_col  = 2'd0;
    logic [3:0]  kc_vec;

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    int vv_cnt = 0;

    keypad_entry_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .rst(rst),
        .KR_0(KR_0), .KR_1(KR_1), .KR_2(KR_2), .KR_3(KR_3),
        .KC_0(KC_0), .KC_1(KC_1), .KC_2(KC_2), .KC_3(KC_3),
        .entry(entry), .value(value), .value_valid(value_valid),
        .key_code(key_code), .key_strobe(key_strobe), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    // Switch matrix: a pressed row reads low only while its key's column is driven low.
    assign kc_vec = {KC_3, KC_2, KC_1, KC_0};
    always_comb begin
        KR_0 = ~(key_rows[0] & ~kc_vec[key_col]);
        KR_1 = ~(key_rows[1] & ~kc_vec[key_col]);
        KR_2 = ~(key_rows[2] & ~kc_vec[key_col]);
        KR_3 = ~(key_rows[3] & ~kc_vec[key_col]);
    end

    always @(posedge clk) begin
        if (key_strobe)  strobe_cnt <= strobe_cnt + 1;
        if (value_valid) vv_cnt     <= vv_cnt + 1;
    end

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        int         code;
        int         ent;
        int         cnt;
        int         val;
        int         vv;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_strobe(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (key_strobe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no key_strobe within 400 cycles", name);
        end
    endtask

    task automatic wait_col_fall(input int c);
        logic prev;
        prev = kc_vec[c];
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (prev && !kc_vec[c]) return;
            prev = kc_vec[c];
        end
        n_tests++;
        n_fail++;
        $display("FAIL col_fall: column %0d never driven low", c);
    endtask

    task automatic release_and_settle();
        key_rows = 4'h0;
        repeat (20 * SD) @(negedge clk);
    endtask

    // Press a key for a sequence of whole dwells of column 0; lows[i] = 1 means held during dwell i.
    task automatic dwell_pattern(input logic [3:0] mask, input int n, input logic [7:0] lows);
        wait_col_fall(0);
        key_col = 2'd0;
        for (int i = 0; i < n; i++) begin
            key_rows = lows[i] ? mask : 4'h0;
            repeat (SD) @(negedge clk);
        end
        key_rows = 4'h0;
    endtask

    initial begin
        bit ok;
        int s0, v0;

        //              r     c     code  entry cnt value vv
        vecs[0]  = '{2'd1, 2'd1, 5,  5,    1, 0,    0};  // 5
        vecs[1]  = '{2'd3, 2'd0, 14, 0,    0, 0,    0};  // *
        vecs[2]  = '{2'd0, 2'd0, 1,  1,    1, 0,    0};  // 1
        vecs[3]  = '{2'd0, 2'd1, 2,  12,   2, 0,    0};  // 2
        vecs[4]  = '{2'd0, 2'd2, 3,  123,  3, 0,    0};  // 3
        vecs[5]  = '{2'd1, 2'd0, 4,  1234, 4, 0,    0};  // 4
        vecs[6]  = '{2'd1, 2'd1, 5,  1234, 4, 0,    0};  // 5 ignored
        vecs[7]  = '{2'd3, 2'd2, 15, 0,    0, 1234, 1};  // #
        vecs[8]  = '{2'd2, 2'd2, 9,  9,    1, 1234, 0};  // 9
        vecs[9]  = '{2'd3, 2'd0, 14, 0,    0, 1234, 0};  // *
        vecs[10] = '{2'd3, 2'd2, 15, 0,    0, 0,    1};  // # empty
        vecs[11] = '{2'd0, 2'd3, 10, 0,    0, 0,    0};  // A
        vecs[12] = '{2'd3, 2'd1, 0,  0,    1, 0,    0};  // 0
        vecs[13] = '{2'd2, 2'd0, 7,  7,    2, 0,    0};  // 7
        vecs[14] = '{2'd3, 2'd3, 13, 7,    2, 0,    0};  // D
        vecs[15] = '{2'd3, 2'd2, 15, 0,    0, 7,    1};  // #

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_entry", int'(entry), 0);
        check("rst_value", int'(value), 0);
        check("rst_count", int'(digit_count), 0);
        check("rst_code", int'(key_code), 0);
        check("rst_strobe", int'(key_strobe), 0);
        check("rst_kc", int'(kc_vec), 4'b1110);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            s0 = strobe_cnt;
            v0 = vv_cnt;
            key_col  = vecs[i].c;
            key_rows = 4'b0001 << vecs[i].r;
            wait_strobe($sformatf("vec%0d_strobe", i), ok);
            if (ok) begin
                check($sformatf("vec%0d_code", i), int'(key_code), vecs[i].code);
                check($sformatf("vec%0d_entry", i), int'(entry), vecs[i].ent);
                check($sformatf("vec%0d_count", i), int'(digit_count), vecs[i].cnt);
                check($sformatf("vec%0d_value", i), int'(value), vecs[i].val);
                check($sformatf("vec%0d_vv", i), int'(value_valid), vecs[i].vv);
            end
            repeat (3 * SD) @(negedge clk);
            release_and_settle();
            check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, 1);
            check($sformatf("vec%0d_vv_pulses", i), vv_cnt - v0, vecs[i].vv);
            check($sformatf("vec%0d_kc_onehot", i), $countones(~kc_vec), 1);
        end

        // Rows 1 and 2 low together in column 0: row 1 ('4') decodes.
        s0 = strobe_cnt;
        key_col  = 2'd0;
        key_rows = 4'b0110;
        wait_strobe("multirow_strobe", ok);
        if (ok) begin
            check("multirow_code", int'(key_code), 4);
            check("multirow_entry", int'(entry), 4);
        end
        repeat (2 * SD) @(negedge clk);
        release_and_settle();
        check("multirow_strobes", strobe_cnt - s0, 1);

`ifdef KEYPAD_DEBOUNCE_EN
        // Bounced '7': low-high, low-low-high, then steady low.
        s0 = strobe_cnt;
        dwell_pattern(4'b0100, 2, 8'b0000_0001);
        repeat (4 * SD) @(negedge clk);
        check("bounce1_strobes", strobe_cnt - s0, 0);
        dwell_pattern(4'b0100, 3, 8'b0000_0011);
        repeat (4 * SD) @(negedge clk);
        check("bounce2_strobes", strobe_cnt - s0, 0);
        dwell_pattern(4'b0100, 6, 8'b0011_1111);
        release_and_settle();
        check("bounce3_strobes", strobe_cnt - s0, 1);
        check("bounce3_code", int'(key_code), 7);
        check("bounce3_entry", int'(entry), 47);
        check("bounce3_count", int'(digit_count), 2);
`else
        // 'A' held for a single dwell of column 3.
        s0 = strobe_cnt;
        wait_col_fall(3);
        key_col  = 2'd3;
        key_rows = 4'b0001;
        repeat (SD) @(negedge clk);
        release_and_settle();
        check("single_dwell_strobes", strobe_cnt - s0, 1);
        check("single_dwell_code", int'(key_code), 10);
        check("single_dwell_entry", int'(entry), 4);
        check("single_dwell_count", int'(digit_count), 1);
`endif

        // Hold '1', reset during PRESSED, then expect exactly one re-detection.
        key_col  = 2'd0;
        key_rows = 4'b0001;
        wait_strobe("prereset_strobe", ok);
        repeat (2 * SD) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_entry", int'(entry), 0);
        check("midrst_value", int'(value), 0);
        check("midrst_count", int'(digit_count), 0);
        check("midrst_code", int'(key_code), 0);
        check("midrst_strobe", int'(key_strobe), 0);
        check("midrst_vv", int'(value_valid), 0);
        check("midrst_kc", int'(kc_vec), 4'b1110);
        repeat (3) @(negedge clk);
        s0 = strobe_cnt;
        rst = 1'b0;
        wait_strobe("postrst_strobe", ok);
        if (ok) begin
            check("postrst_code", int'(key_code), 1);
            check("postrst_entry", int'(entry), 1);
            check("postrst_count", int'(digit_count), 1);
        end
        repeat (5 * SD) @(negedge clk);
        release_and_settle();
        check("postrst_strobes", strobe_cnt - s0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
